// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg: shared opcodes, saturation constants and byte-lane helpers
// for the mlaccel accumulate/store back end.
// Optional build macro used by this block: MLACCEL_ACC_ROUND_EN (see lane).
package mlaccel_pkg;

  localparam logic [2:0] OP_ADD        = 3'd0;
  localparam logic [2:0] OP_ADDZ       = 3'd1;
  localparam logic [2:0] OP_MAX        = 3'd2;
  localparam logic [2:0] OP_MAXZ       = 3'd3;
  localparam logic [2:0] OP_STORE      = 3'd4;
  localparam logic [2:0] OP_STORE_RELU = 3'd5;
  localparam logic [2:0] OP_SET_SBP    = 3'd6;
  localparam logic [2:0] OP_ADD_SBP    = 3'd7;

  localparam logic [7:0] SAT_MAX = 8'h7F;
  localparam logic [7:0] SAT_MIN = 8'h80;

  // Byte position of channel c inside its word, given the word offset.
  function automatic int byte_lane(input int off, input int c, input int nbytes);
    return (off + c) % nbytes;
  endfunction

  // Channel c lands in the following word when it runs past the last byte.
  function automatic logic is_spill(input int off, input int c, input int nbytes);
    return (off + c) >= nbytes;
  endfunction

endpackage

// File: rtl/mlaccel_accum_store_if.sv
// mlaccel_accum_store_if: command and memory-write bundle.
//   in_*   : command channel (valid/ready), products, store controls
//   mem_*  : word write channel (valid/ready), byte enables, word address, data
//   busy   : write stage occupied
// Modports: master = command source / memory sink, slave = the back end.
interface mlaccel_accum_store_if #(
  parameter int NCH       = 2,
  parameter int SZ        = 8,
  parameter int PW        = 16,
  parameter int MEM_BYTES = 8,
  parameter int ADDR_W    = 17
);
  localparam int WA = ADDR_W - $clog2(MEM_BYTES);

  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_op;
  logic [4:0]             in_shift;
  logic [NCH-1:0]         in_chmask;
  logic [ADDR_W-1:0]      in_addr;
  logic [NCH*SZ*PW-1:0]   in_prod;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [MEM_BYTES-1:0]   mem_wen;
  logic [WA-1:0]          mem_addr;
  logic [8*MEM_BYTES-1:0] mem_wdata;
  logic                   busy;

  modport master (
    output in_valid, in_op, in_shift, in_chmask, in_addr, in_prod, mem_ready,
    input  in_ready, mem_valid, mem_wen, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  in_valid, in_op, in_shift, in_chmask, in_addr, in_prod, mem_ready,
    output in_ready, mem_valid, mem_wen, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mlaccel_accum_lane.sv
// mlaccel_accum_lane: one channel's accumulator.
//   upd/op : update acc with add/addz/max/maxz reduction of SZ products
//   prod   : SZ signed PW-bit products, lane i at [i*PW +: PW]
//   shift/relu -> q : acc shifted, saturated to int8, optional ReLU
// MLACCEL_ACC_ROUND_EN: round-half-up before the shift instead of truncating.
module mlaccel_accum_lane
  import mlaccel_pkg::*;
#(
  parameter int SZ = 8,
  parameter int PW = 16,
  parameter int AW = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             upd,
  input  logic [1:0]       op,
  input  logic [SZ*PW-1:0] prod,
  input  logic [4:0]       shift,
  input  logic             relu,
  output logic [7:0]       q
);
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW:0]   HI      = (AW+1)'(127);
  localparam logic signed [AW:0]   LO      = -HI - 1;

  logic signed [AW-1:0] acc, sum, pmax, base, acc_nxt, p;
  logic signed [AW:0]   ext, shv;

  // op[1] selects max vs add, op[0] selects the Z (fresh start) variant.
  always_comb begin
    sum  = '0;
    pmax = ACC_MIN;
    p    = '0;
    for (int i = 0; i < SZ; i++) begin
      p    = {{(AW-PW){prod[i*PW+PW-1]}}, prod[i*PW +: PW]};
      sum  = sum + p;
      if (p > pmax) pmax = p;
    end
    if (op[1]) begin
      base    = op[0] ? ACC_MIN : acc;
      acc_nxt = (pmax > base) ? pmax : base;
    end else begin
      base    = op[0] ? '0 : acc;
      acc_nxt = base + sum;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  acc <= '0;
    else if (upd) acc <= acc_nxt;
  end

  // One extra bit keeps the rounding add from overflowing.
  always_comb begin
    ext = {acc[AW-1], acc};
`ifdef MLACCEL_ACC_ROUND_EN
    if (shift != 5'd0) ext = ext + ((AW+1)'(1) << (shift - 5'd1));
`endif
    shv = ext >>> shift;
    if (relu && shv[AW]) q = 8'h00;
    else if (shv > HI)   q = SAT_MAX;
    else if (shv < LO)   q = SAT_MIN;
    else                 q = shv[7:0];
  end

endmodule

// File: rtl/mlaccel_accum_store.sv
// mlaccel_accum_store: accumulate / post-process / store back end.
//   clock, resetn : clock, async active-low reset
//   io (slave)    : command channel in, memory write channel out, busy
// NCH accumulators updated by ADD/ADDZ/MAX/MAXZ; STORE/STORE_RELU write one
// int8 per channel at SBP+in_addr, splitting into a second beat when the
// bytes run past the end of the memory word.
// Optional build macro: MLACCEL_ACC_ROUND_EN (rounded stores, in the lane).
module mlaccel_accum_store
  import mlaccel_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int SZ        = 8,
  parameter int PW        = 16,
  parameter int AW        = 32,
  parameter int MEM_BYTES = 8,
  parameter int ADDR_W    = 17
) (
  input logic                  clock,
  input logic                  resetn,
  mlaccel_accum_store_if.slave io
);
  localparam int OB = $clog2(MEM_BYTES);
  localparam int WA = ADDR_W - OB;

  logic [NCH-1:0][7:0] lane_q;
  logic                accept, retire, occ, acc_upd, is_store, relu;
  logic [ADDR_W-1:0]   sbp, ea;
  logic [OB-1:0]       off, ln;
  logic [WA-1:0]       wa0;

  logic [MEM_BYTES-1:0]      w1_wen, w2_wen;
  logic [MEM_BYTES-1:0][7:0] w1_data, w2_data;

  // Write stage: m_* is the beat on the bus, p_* the pending spill beat.
  logic                      mv, pv;
  logic [MEM_BYTES-1:0]      m_wen, p_wen;
  logic [WA-1:0]             m_addr, p_addr;
  logic [MEM_BYTES-1:0][7:0] m_data, p_data;

  assign retire   = mv && io.mem_ready;
  assign occ      = mv || pv;
  assign io.in_ready = !occ || (retire && !pv);
  assign accept   = io.in_valid && io.in_ready;
  assign acc_upd  = accept && (io.in_op == OP_ADD || io.in_op == OP_ADDZ ||
                               io.in_op == OP_MAX || io.in_op == OP_MAXZ);
  assign is_store = io.in_op == OP_STORE || io.in_op == OP_STORE_RELU;
  assign relu     = io.in_op == OP_STORE_RELU;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mlaccel_accum_lane #(.SZ(SZ), .PW(PW), .AW(AW)) u_lane (
      .clock  (clock),
      .resetn (resetn),
      .upd    (acc_upd),
      .op     (io.in_op[1:0]),
      .prod   (io.in_prod[c*SZ*PW +: SZ*PW]),
      .shift  (io.in_shift),
      .relu   (relu),
      .q      (lane_q[c])
    );
  end

  assign ea  = io.in_addr + sbp;
  assign off = ea[OB-1:0];
  assign wa0 = ea[ADDR_W-1:OB];

  always_comb begin
    w1_wen  = '0;
    w2_wen  = '0;
    w1_data = '0;
    w2_data = '0;
    ln      = '0;
    for (int c = 0; c < NCH; c++) begin
      ln = OB'(byte_lane(int'(off), c, MEM_BYTES));
      if (is_spill(int'(off), c, MEM_BYTES)) begin
        w2_wen[ln]  = io.in_chmask[c];
        w2_data[ln] = io.in_chmask[c] ? lane_q[c] : 8'h00;
      end else begin
        w1_wen[ln]  = io.in_chmask[c];
        w1_data[ln] = io.in_chmask[c] ? lane_q[c] : 8'h00;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sbp    <= '0;
      mv     <= 1'b0;
      pv     <= 1'b0;
      m_wen  <= '0;
      m_addr <= '0;
      m_data <= '0;
      p_wen  <= '0;
      p_addr <= '0;
      p_data <= '0;
    end else begin
      if (accept && io.in_op == OP_SET_SBP)      sbp <= io.in_addr;
      else if (accept && io.in_op == OP_ADD_SBP) sbp <= sbp + io.in_addr;

      if (accept && is_store) begin
        // A store is only accepted when nothing is left queued behind it.
        if (|w1_wen) begin
          mv     <= 1'b1;
          m_wen  <= w1_wen;
          m_addr <= wa0;
          m_data <= w1_data;
          pv     <= |w2_wen;
          p_wen  <= w2_wen;
          p_addr <= wa0 + WA'(1);
          p_data <= w2_data;
        end else if (|w2_wen) begin
          mv     <= 1'b1;
          m_wen  <= w2_wen;
          m_addr <= wa0 + WA'(1);
          m_data <= w2_data;
          pv     <= 1'b0;
        end else begin
          mv     <= 1'b0;
          m_wen  <= '0;
          pv     <= 1'b0;
        end
      end else if (retire) begin
        if (pv) begin
          m_wen  <= p_wen;
          m_addr <= p_addr;
          m_data <= p_data;
          pv     <= 1'b0;
        end else begin
          mv     <= 1'b0;
          m_wen  <= '0;
        end
      end
    end
  end

  assign io.mem_valid = mv;
  assign io.mem_wen   = m_wen;
  assign io.mem_addr  = m_addr;
  assign io.mem_wdata = m_data;
  assign io.busy      = occ;

endmodule
